// File: rtl/ntt_bf_sched.sv
// Butterfly scheduler for a 256-point NTT/INTT: walks 7 layers x 128 butterflies,
// feeds a pipelined PE and writes results back via an address queue.
module ntt_bf_sched #(
   parameter int unsigned PE_LAT   = 4,
   parameter int unsigned AQ_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        mode_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        rd_en_o,
   output logic [7:0]  rd_addr0_o,
   output logic [7:0]  rd_addr1_o,
   input  logic [11:0] rd_data0_i,
   input  logic [11:0] rd_data1_i,
   output logic [6:0]  tw_addr_o,
   input  logic [11:0] tw_data_i,
   output logic [11:0] pe_a_o,
   output logic [11:0] pe_b_o,
   output logic [11:0] pe_w_o,
   output logic [3:0]  pe_ctrl_o,
   output logic        pe_valid_o,
   input  logic [11:0] pe_u_i,
   input  logic [11:0] pe_v_i,
   input  logic        pe_valid_i,
   output logic        wr_en_o,
   output logic [7:0]  wr_addr0_o,
   output logic [7:0]  wr_addr1_o,
   output logic [11:0] wr_data0_o,
   output logic [11:0] wr_data1_o
);

   localparam int unsigned AW  = 8;
   localparam int unsigned KW  = 7;
   localparam int unsigned QAW = (AQ_DEPTH > 1) ? $clog2(AQ_DEPTH) : 1;
   localparam int unsigned QCW = $clog2(AQ_DEPTH + 1);
   localparam int unsigned FW  = $clog2(PE_LAT + 2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          mode_q, mode_d;
   logic [2:0]    l_q, l_d;
   logic [6:0]    bf_q, bf_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr0_q, rd_addr0_d, rd_addr1_q, rd_addr1_d;
   logic [KW-1:0] tw_addr_q, tw_addr_d;
   logic          pe_valid_q, pe_valid_d;
   logic [AW-1:0] p_addr0_q, p_addr0_d, p_addr1_q, p_addr1_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [3:0]    ctrl_q, ctrl_d;
   logic [QAW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [QCW-1:0] cnt_q, cnt_d;
   logic [FW-1:0]  flush_q, flush_d;
   logic [2*AW-1:0] aq_q [AQ_DEPTH];

   logic [2:0]    shamt;
   logic [AW-1:0] bf8, lo_mask, addr0_w, addr1_w, grp_w;
   logic [KW-1:0] tw_w;
   logic          push, pop, err_set, accept, layer_done;

   // Next-state, address generation and address-queue bookkeeping
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      l_d        = l_q;
      bf_d       = bf_q;
      rd_en_d    = 1'b0;
      rd_addr0_d = '0;
      rd_addr1_d = '0;
      tw_addr_d  = '0;
      pe_valid_d = rd_en_q;
      p_addr0_d  = rd_addr0_q;
      p_addr1_d  = rd_addr1_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      flush_d    = (flush_q != '0) ? FW'(flush_q - FW'(1)) : '0;
      accept     = 1'b0;
      layer_done = 1'b0;

      // Butterfly span is 2^shamt; addr0 is bf with a zero inserted at bit shamt
      shamt   = mode_q ? 3'(l_q + 3'd1) : 3'(3'd7 - l_q);
      bf8     = {1'b0, bf_q};
      lo_mask = AW'((8'd1 << shamt) - 8'd1);
      addr0_w = AW'(((bf8 & ~lo_mask) << 1) | (bf8 & lo_mask));
      addr1_w = addr0_w | AW'(8'd1 << shamt);
      grp_w   = bf8 >> shamt;
      tw_w    = mode_q ? KW'((8'd128 >> l_q) - 8'd1 - grp_w)
                       : KW'((8'd1 << l_q) + grp_w);

      // Results returning within the post-reset window belong to an aborted run
      push    = pe_valid_q;
      pop     = pe_valid_i && (cnt_q != '0) && (flush_q == '0);
      err_set = pe_valid_i && (cnt_q == '0) && (flush_q == '0);

      if (push) wptr_d = (wptr_q == QAW'(AQ_DEPTH - 1)) ? '0 : QAW'(wptr_q + QAW'(1));
      if (pop)  rptr_d = (rptr_q == QAW'(AQ_DEPTH - 1)) ? '0 : QAW'(rptr_q + QAW'(1));
      if (push && !pop)      cnt_d = QCW'(cnt_q + QCW'(1));
      else if (pop && !push) cnt_d = QCW'(cnt_q - QCW'(1));

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               accept  = 1'b1;
               state_d = S_ISSUE;
               mode_d  = mode_i;
               l_d     = '0;
               bf_d    = '0;
            end
         end
         S_ISSUE: begin
            rd_en_d    = 1'b1;
            rd_addr0_d = addr0_w;
            rd_addr1_d = addr1_w;
            tw_addr_d  = tw_w;
            bf_d       = 7'(bf_q + 7'd1);
            if (bf_q == 7'd127) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Next layer only once every write of this layer has left
            layer_done = (cnt_d == '0) && !pe_valid_q && !rd_en_q;
            if (layer_done) begin
               if (l_q == 3'd6) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  l_d     = 3'(l_q + 3'd1);
                  bf_d    = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      err_d  = accept ? 1'b0 : (err_q | err_set);
      busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      ctrl_d = (state_d == S_IDLE) ? 4'd0 : {3'b000, mode_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         l_q        <= '0;
         bf_q       <= '0;
         rd_en_q    <= 1'b0;
         rd_addr0_q <= '0;
         rd_addr1_q <= '0;
         tw_addr_q  <= '0;
         pe_valid_q <= 1'b0;
         p_addr0_q  <= '0;
         p_addr1_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ctrl_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         flush_q    <= FW'(PE_LAT + 1);
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         l_q        <= l_d;
         bf_q       <= bf_d;
         rd_en_q    <= rd_en_d;
         rd_addr0_q <= rd_addr0_d;
         rd_addr1_q <= rd_addr1_d;
         tw_addr_q  <= tw_addr_d;
         pe_valid_q <= pe_valid_d;
         p_addr0_q  <= p_addr0_d;
         p_addr1_q  <= p_addr1_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ctrl_q     <= ctrl_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         flush_q    <= flush_d;
      end
   end

   // Address-queue storage; occupancy is tracked by the pointers above
   always_ff @(posedge clk) begin
      if (!rst && push) aq_q[wptr_q] <= {p_addr0_q, p_addr1_q};
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign rd_en_o    = rd_en_q;
   assign rd_addr0_o = rd_addr0_q;
   assign rd_addr1_o = rd_addr1_q;
   assign tw_addr_o  = tw_addr_q;
   assign pe_valid_o = pe_valid_q;
   assign pe_ctrl_o  = ctrl_q;
   assign pe_a_o     = pe_valid_q ? rd_data0_i : '0;
   assign pe_b_o     = pe_valid_q ? rd_data1_i : '0;
   assign pe_w_o     = pe_valid_q ? tw_data_i  : '0;
   assign wr_en_o    = pop && !rst;
   assign wr_addr0_o = wr_en_o ? aq_q[rptr_q][2*AW-1:AW] : '0;
   assign wr_addr1_o = wr_en_o ? aq_q[rptr_q][AW-1:0]    : '0;
   assign wr_data0_o = wr_en_o ? pe_u_i : '0;
   assign wr_data1_o = wr_en_o ? pe_v_i : '0;

endmodule
